instruction_fetch_sequencer: RTL and testbench

//  Fetches one 16-bit instruction word from byte-wide memory in two read transactions
//  and presents it to the decode stage over a valid/ready handshake.

---
 rtl/instruction_fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_sequencer.sv
// Two-byte instruction fetch sequencer: reads a 16-bit word from byte memory
// at the PC, steps the PC per byte, and hands the word to decode via valid/ready.
//
// Ports:
//   Clock, Reset        rising-edge clock, async active-high reset
//   Start               fetch request (IDLE, HOLD with InstrReady, ERR)
//   PcQ                 current PC value
//   PcE, PcFunSel       PC enable / function (01 inc, 00 dec)
//   MemAddr, MemRead    byte read request (address = PcQ while reading)
//   MemData, MemValid   byte read response
//   InstrOut            assembled instruction word
//   InstrValid          InstrOut valid (HOLD)
//   InstrReady          consumer accept
//   Busy, Error         fetching / timed out
module instruction_fetch_sequencer #(
    parameter bit LOW_FIRST = 1'b1,
    parameter int TIMEOUT   = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] PcQ,
    output logic        PcE,
    output logic [1:0]  PcFunSel,
    output logic [15:0] MemAddr,
    output logic        MemRead,
    input  logic [7:0]  MemData,
    input  logic        MemValid,
    output logic [15:0] InstrOut,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic        Busy,
    output logic        Error
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        REQ_HI,
        HOLD,
        ERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     instr_q, instr_d;
    logic            valid_q, busy_q, err_q;

    logic            req;
    logic            tmo;
    logic            first;

    assign InstrOut   = instr_q;
    assign InstrValid = valid_q;
    assign Busy       = busy_q;
    assign Error      = err_q;

    // Mealy memory/PC controls; a response in the timeout cycle wins.
    always_comb begin
        req   = (state_q == REQ_LO) || (state_q == REQ_HI);
        first = (state_q == REQ_LO);
        tmo   = (TIMEOUT != 0) && req && !MemValid && (cnt_q == LAST);

        MemRead  = req;
        MemAddr  = req ? PcQ : 16'h0000;
        PcE      = (req && MemValid) || ((state_q == REQ_HI) && tmo);
        // Rolling back from REQ_HI lets a retry refetch the whole word.
        PcFunSel = ((state_q == REQ_HI) && tmo) ? 2'b00 : 2'b01;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (Start) state_d = REQ_LO;
            end
            REQ_LO, REQ_HI: begin
                if (MemValid) begin
                    if (first == LOW_FIRST) instr_d[7:0] = MemData;
                    else                    instr_d[15:8] = MemData;
                    state_d = first ? REQ_HI : HOLD;
                end else if (tmo) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (InstrReady) state_d = Start ? REQ_LO : IDLE;
            end
            ERR: begin
                if (Start) state_d = REQ_LO;
            end
            default: state_d = IDLE;
        endcase
        // Fresh wait budget for every byte request.
        if ((state_d != state_q) &&
            ((state_d == REQ_LO) || (state_d == REQ_HI)))
            cnt_d = '0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d == REQ_LO) || (state_d == REQ_HI);
            err_q   <= (state_d == ERR);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer: PC and byte memory
// models, two instances covering both byte orders.
module tb_instruction_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2, rdy, mem_en;
    logic        pc_ld;
    logic [15:0] pc_val;

    logic        pe1, rd1, iv1, busy1, err1, mv1;
    logic [1:0]  fs1;
    logic [15:0] addr1, iout1, pc1;
    logic [7:0]  md1;

    logic        pe2, rd2, iv2, busy2, err2, mv2;
    logic [1:0]  fs2;
    logic [15:0] addr2, iout2, pc2;
    logic [7:0]  md2;

    logic [7:0]  mem [0:1023];
    int          pe_cnt, dec_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign md1 = mem[addr1[9:0]];
    assign mv1 = rd1 & mem_en;
    assign md2 = mem[addr2[9:0]];
    assign mv2 = rd2;

    always @(posedge clk) begin
        if (pc_ld) begin
            pc1     <= pc_val;
            pc2     <= pc_val;
            pe_cnt  <= 0;
            dec_cnt <= 0;
        end else begin
            if (pe1) begin
                pe_cnt <= pe_cnt + 1;
                if (fs1 == 2'b01) pc1 <= pc1 + 16'd1;
                else if (fs1 == 2'b00) begin
                    pc1     <= pc1 - 16'd1;
                    dec_cnt <= dec_cnt + 1;
                end
            end
            if (pe2) begin
                if (fs2 == 2'b01) pc2 <= pc2 + 16'd1;
                else if (fs2 == 2'b00) pc2 <= pc2 - 16'd1;
            end
        end
    end

    instruction_fetch_sequencer #(.LOW_FIRST(1'b1), .TIMEOUT(8)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .PcQ(pc1),
        .PcE(pe1), .PcFunSel(fs1), .MemAddr(addr1), .MemRead(rd1),
        .MemData(md1), .MemValid(mv1), .InstrOut(iout1),
        .InstrValid(iv1), .InstrReady(rdy), .Busy(busy1), .Error(err1)
    );

    instruction_fetch_sequencer #(.LOW_FIRST(1'b0), .TIMEOUT(8)) dut2 (
        .Clock(clk), .Reset(rst), .Start(start2), .PcQ(pc2),
        .PcE(pe2), .PcFunSel(fs2), .MemAddr(addr2), .MemRead(rd2),
        .MemData(md2), .MemValid(mv2), .InstrOut(iout2),
        .InstrValid(iv2), .InstrReady(rdy), .Busy(busy2), .Error(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; rdy = 1'b0;
        mem_en = 1'b1; pc_ld = 1'b1; pc_val = 16'h0100;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h34; mem[10'h101] = 8'h12;
        mem[10'h200] = 8'hB2; mem[10'h201] = 8'hA1;
        mem[10'h202] = 8'hD4; mem[10'h203] = 8'hC3;
        mem[10'h204] = 8'hF6; mem[10'h205] = 8'hE5;

        // Reset values
        tick; tick;
        pc_ld = 1'b0;
        chk("rst_pce", {31'd0, pe1}, 0);
        chk("rst_fs", {30'd0, fs1}, 1);
        chk("rst_rd", {31'd0, rd1}, 0);
        chk("rst_addr", {16'd0, addr1}, 0);
        chk("rst_iout", {16'd0, iout1}, 0);
        chk("rst_iv", {31'd0, iv1}, 0);
        chk("rst_busy", {31'd0, busy1}, 0);
        chk("rst_err", {31'd0, err1}, 0);
        tick;
        rst = 1'b0;
        tick;

        // Basic fetch, both byte orders
        start = 1'b1; start2 = 1'b1;
        #1;
        chk("idle_busy", {31'd0, busy1}, 0);
        tick;
        start = 1'b0; start2 = 1'b0;
        #1;
        chk("lo_rd", {31'd0, rd1}, 1);
        chk("lo_addr", {16'd0, addr1}, 32'h100);
        chk("lo_pce", {31'd0, pe1}, 1);
        chk("lo_fs", {30'd0, fs1}, 1);
        chk("lo_busy", {31'd0, busy1}, 1);
        tick;
        chk("hi_addr", {16'd0, addr1}, 32'h101);
        chk("hi_pce", {31'd0, pe1}, 1);
        chk("hi_iv", {31'd0, iv1}, 0);
        tick;
        chk("hold_iv", {31'd0, iv1}, 1);
        chk("hold_iout", {16'd0, iout1}, 32'h1234);
        chk("hold_pc", {16'd0, pc1}, 32'h102);
        chk("hold_pecnt", pe_cnt, 2);
        chk("hold_rd", {31'd0, rd1}, 0);
        chk("hf_iv", {31'd0, iv2}, 1);
        chk("hf_iout", {16'd0, iout2}, 32'h3412);

        // Stall in HOLD
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("stall_iv", {31'd0, iv1}, 1);
            chk("stall_iout", {16'd0, iout1}, 32'h1234);
            chk("stall_rd", {31'd0, rd1}, 0);
            chk("stall_pce", {31'd0, pe1}, 0);
        end
        chk("stall_pc", {16'd0, pc1}, 32'h102);
        rdy = 1'b1;
        tick;
        chk("rel_iv", {31'd0, iv1}, 0);
        chk("rel_busy", {31'd0, busy1}, 0);
        chk("rel_iout", {16'd0, iout1}, 32'h1234);

        // Back-to-back fetches
        pc_ld = 1'b1; pc_val = 16'h0200;
        tick;
        pc_ld = 1'b0;
        start = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tick;
            chk("b2b_busy", {31'd0, busy1}, 1);
            chk("b2b_addr", {16'd0, addr1}, 32'h200 + 2 * w);
            tick;
            tick;
            chk("b2b_iv", {31'd0, iv1}, 1);
            case (w)
                0: chk("b2b_w0", {16'd0, iout1}, 32'hA1B2);
                1: chk("b2b_w1", {16'd0, iout1}, 32'hC3D4);
                default: chk("b2b_w2", {16'd0, iout1}, 32'hE5F6);
            endcase
        end
        start = 1'b0;
        tick;
        chk("b2b_pc", {16'd0, pc1}, 32'h206);
        chk("b2b_idle", {31'd0, busy1}, 0);

        // Timeout on the high byte with rollback
        pc_ld = 1'b1; pc_val = 16'h0100;
        tick;
        pc_ld = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        chk("to_lo_pce", {31'd0, pe1}, 1);
        tick;
        mem_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("to_wait_pce", {31'd0, pe1}, 0);
            chk("to_wait_err", {31'd0, err1}, 0);
            tick;
        end
        #1;
        chk("to_fire_pce", {31'd0, pe1}, 1);
        chk("to_fire_fs", {30'd0, fs1}, 0);
        tick;
        chk("to_err", {31'd0, err1}, 1);
        chk("to_iv", {31'd0, iv1}, 0);
        chk("to_busy", {31'd0, busy1}, 0);
        chk("to_rd", {31'd0, rd1}, 0);
        chk("to_pc", {16'd0, pc1}, 32'h100);
        chk("to_pecnt", pe_cnt, 2);
        chk("to_deccnt", dec_cnt, 1);
        tick;
        chk("err_stay", {31'd0, err1}, 1);
        start = 1'b1; mem_en = 1'b1;
        tick;
        start = 1'b0;
        #1;
        chk("retry_addr", {16'd0, addr1}, 32'h100);
        chk("retry_err", {31'd0, err1}, 0);
        tick;
        chk("retry_hi", {16'd0, addr1}, 32'h101);
        tick;
        chk("retry_iout", {16'd0, iout1}, 32'h1234);
        chk("retry_iv", {31'd0, iv1}, 1);
        tick;

        // Response in the timeout cycle wins
        start = 1'b1; mem_en = 1'b0;
        tick;
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        mem_en = 1'b1;
        #1;
        chk("win_pce", {31'd0, pe1}, 1);
        chk("win_fs", {30'd0, fs1}, 1);
        tick;
        mem_en = 1'b0;
        #1;
        chk("win_err", {31'd0, err1}, 0);
        chk("win_busy", {31'd0, busy1}, 1);
        chk("win_addr", {16'd0, addr1}, 32'h103);

        // Reset during REQ_HI
        rst = 1'b1;
        #1;
        chk("mr_pce", {31'd0, pe1}, 0);
        chk("mr_fs", {30'd0, fs1}, 1);
        chk("mr_busy", {31'd0, busy1}, 0);
        chk("mr_rd", {31'd0, rd1}, 0);
        chk("mr_addr", {16'd0, addr1}, 0);
        chk("mr_iout", {16'd0, iout1}, 0);
        chk("mr_err", {31'd0, err1}, 0);
        tick;
        rst = 1'b0;
        tick;
        chk("mr_idle", {31'd0, busy1}, 0);
        chk("mr_pc", {16'd0, pc1}, 32'h103);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
